// File: rtl/bram_arb_pkg.sv
// ----------------------------------------------------------------------------
// bram_arb_pkg
// Shared types and constants for the BRAM access arbiter.
//   state_t : access sequencer states (IDLE -> ACCESS -> DONE -> IDLE)
//   owner_t : which requester owns the access in flight
//   CNT_W   : width of the access-window counter (window length up to 15)
// ----------------------------------------------------------------------------
package bram_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_WB  = 1'b0,
    OWN_ENG = 1'b1
  } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way grant logic for the BRAM arbiter. Purely combinational.
//   i_req_wb   : Wishbone path requesting
//   i_req_eng  : engine port requesting
//   i_last_gnt : owner of the most recent grant
//   o_gnt      : one-hot grant, [0] = WB, [1] = ENG (all zero when idle)
// Build option BRAM_ARB_FIXED_PRIO_EN: when defined, WB wins every tie and
// i_last_gnt is ignored; when undefined, ties go to the port that was not
// granted last (round-robin).
// ----------------------------------------------------------------------------
module rr_arb2
  import bram_arb_pkg::*;
(
  input  logic       i_req_wb,
  input  logic       i_req_eng,
  input  owner_t     i_last_gnt,
  output logic [1:0] o_gnt
);

`ifdef BRAM_ARB_FIXED_PRIO_EN
  logic w_unused_last_gnt;
  assign w_unused_last_gnt = i_last_gnt;

  assign o_gnt[0] = i_req_wb;
  assign o_gnt[1] = i_req_eng & ~i_req_wb;
`else
  // A lone requester always wins; on a tie the port not granted last wins.
  assign o_gnt[0] = i_req_wb  & (~i_req_eng | (i_last_gnt == OWN_ENG));
  assign o_gnt[1] = i_req_eng & (~i_req_wb  | (i_last_gnt == OWN_WB));
`endif

endmodule

// File: rtl/bram_access_arbiter.sv
// ----------------------------------------------------------------------------
// bram_access_arbiter
// Shares one single-port BRAM between the Wishbone slave path and a local
// engine port. Arbitrates, holds address/data for a fixed ACC_DELAY-cycle
// window, raises byte write enables only in the last WE_CYCLES cycles of the
// window, captures read data at the end of the window and returns ack/done.
//
// Parameters:
//   ACC_DELAY : access window length in cycles (2..15)
//   WE_CYCLES : final window cycles with write enable active (1..ACC_DELAY)
// Ports:
//   wb_clk_i, wb_rst_n_i          : clock, async active-low reset
//   wbs_cyc_i/stb_i/we_i/sel_i    : Wishbone request qualifiers
//   wbs_adr_i/dat_i               : Wishbone address / write data
//   wbs_ack_o/dat_o               : Wishbone ack / read data (DONE only)
//   eng_req_i/we_i/sel_i/adr_i/dat_i : engine request
//   eng_gnt_o                     : engine accepted (pulse, in the IDLE cycle)
//   eng_done_o/eng_rdata_o        : engine complete pulse / read data (held)
//   bram_en_o/we_o/a_o/di_o       : BRAM control, address, write data
//   bram_do_i                     : BRAM read data
// Build option BRAM_ARB_FIXED_PRIO_EN: fixed priority (WB wins ties) instead
// of round-robin; see rr_arb2.
// ----------------------------------------------------------------------------
module bram_access_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ACC_DELAY = 10,
  parameter int WE_CYCLES = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        eng_req_i,
  input  logic        eng_we_i,
  input  logic [3:0]  eng_sel_i,
  input  logic [31:0] eng_adr_i,
  input  logic [31:0] eng_dat_i,
  output logic        eng_gnt_o,
  output logic        eng_done_o,
  output logic [31:0] eng_rdata_o,
  output logic        bram_en_o,
  output logic [3:0]  bram_we_o,
  output logic [31:0] bram_a_o,
  output logic [31:0] bram_di_o,
  input  logic [31:0] bram_do_i
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(ACC_DELAY);
  // Write enable is active while the window counter is above this value.
  localparam logic [CNT_W-1:0] C_WE_AFTER = CNT_W'(ACC_DELAY - WE_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  owner_t           r_owner;
  owner_t           r_last_gnt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [3:0]       r_sel;
  logic             r_abort;
  logic             r_bram_en;
  logic [3:0]       r_bram_we;
  logic [31:0]      r_bram_a;
  logic [31:0]      r_bram_di;
  logic             r_wbs_ack;
  logic [31:0]      r_wbs_dat;
  logic             r_eng_done;
  logic [31:0]      r_eng_rdata;

  logic             w_req_wb;
  logic             w_req_eng;
  logic [1:0]       w_gnt;
  logic             w_we_in;
  logic [3:0]       w_sel_in;
  logic [31:0]      w_adr_in;
  logic [31:0]      w_dat_in;
  logic [3:0]       w_lane_we_in;
  logic [3:0]       w_lane_we;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_abort_now;

  assign w_req_wb  = wbs_cyc_i & wbs_stb_i;
  assign w_req_eng = eng_req_i;

  rr_arb2 u_arb (
    .i_req_wb   (w_req_wb),
    .i_req_eng  (w_req_eng),
    .i_last_gnt (r_last_gnt),
    .o_gnt      (w_gnt)
  );

  // Request fields of whichever port wins this cycle (only used in IDLE).
  assign w_we_in  = w_gnt[1] ? eng_we_i  : wbs_we_i;
  assign w_sel_in = w_gnt[1] ? eng_sel_i : wbs_sel_i;
  assign w_adr_in = w_gnt[1] ? eng_adr_i : wbs_adr_i;
  assign w_dat_in = w_gnt[1] ? eng_dat_i : wbs_dat_i;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane_we_in[gi] = w_sel_in[gi] & w_we_in;
      assign w_lane_we[gi]    = r_sel[gi] & r_we;
    end
  endgenerate

  assign w_cnt_inc = r_cnt + C_CNT_ONE;

  // Abort is visible in the very cycle cyc drops so no enable slips through.
  assign w_abort_now = r_abort | ((r_owner == OWN_WB) & ~wbs_cyc_i);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state     <= IDLE;
      r_owner     <= OWN_WB;
      r_last_gnt  <= OWN_ENG;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_abort     <= 1'b0;
      r_bram_en   <= 1'b0;
      r_bram_we   <= '0;
      r_bram_a    <= '0;
      r_bram_di   <= '0;
      r_wbs_ack   <= 1'b0;
      r_wbs_dat   <= '0;
      r_eng_done  <= 1'b0;
      r_eng_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_owner    <= w_gnt[1] ? OWN_ENG : OWN_WB;
            r_last_gnt <= w_gnt[1] ? OWN_ENG : OWN_WB;
            r_we       <= w_we_in;
            r_sel      <= w_sel_in;
            r_abort    <= 1'b0;
            r_cnt      <= C_CNT_ONE;
            r_bram_en  <= 1'b1;
            r_bram_a   <= w_adr_in;
            r_bram_di  <= w_dat_in;
            // Outputs are registered, so each cycle computes the enables
            // for the counter value of the following cycle.
            r_bram_we  <= (C_CNT_ONE > C_WE_AFTER) ? w_lane_we_in : 4'b0000;
            r_state    <= ACCESS;
          end
        end

        ACCESS: begin
          if ((r_owner == OWN_WB) && !wbs_cyc_i) begin
            r_abort <= 1'b1;
          end
          if (r_cnt == C_CNT_LAST) begin
            r_bram_en <= 1'b0;
            r_bram_we <= '0;
            r_bram_a  <= '0;
            r_bram_di <= '0;
            if (r_owner == OWN_ENG) begin
              r_eng_done  <= 1'b1;
              r_eng_rdata <= bram_do_i;
            end else if (!w_abort_now) begin
              r_wbs_ack <= 1'b1;
              r_wbs_dat <= bram_do_i;
            end
            r_state <= DONE;
          end else begin
            r_cnt     <= w_cnt_inc;
            r_bram_we <= ((w_cnt_inc > C_WE_AFTER) && !w_abort_now) ? w_lane_we : 4'b0000;
          end
        end

        DONE: begin
          r_wbs_ack  <= 1'b0;
          r_wbs_dat  <= '0;
          r_eng_done <= 1'b0;
          r_state    <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // The engine grant is a same-cycle pulse so the engine may move on in the
  // cycle right after its request was latched.
  assign eng_gnt_o   = wb_rst_n_i & (r_state == IDLE) & w_gnt[1];

  assign wbs_ack_o   = r_wbs_ack;
  assign wbs_dat_o   = r_wbs_dat;
  assign eng_done_o  = r_eng_done;
  assign eng_rdata_o = r_eng_rdata;
  assign bram_en_o   = r_bram_en;
  assign bram_we_o   = r_bram_we & {4{~w_abort_now}};
  assign bram_a_o    = r_bram_a;
  assign bram_di_o   = r_bram_di;

endmodule

// File: tb/tb_bram_access_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bram_access_arbiter
// Directed bench for bram_access_arbiter with a small read-first BRAM model.
// Cycle 0 of each scenario is the cycle in which the request is first
// presented; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bram_access_arbiter;

`ifdef BRAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wbs_cyc, wbs_stb, wbs_we;
  logic [3:0]  wbs_sel;
  logic [31:0] wbs_adr, wbs_dat;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        eng_req, eng_we;
  logic [3:0]  eng_sel;
  logic [31:0] eng_adr, eng_dat;
  logic        eng_gnt_o, eng_done_o;
  logic [31:0] eng_rdata_o;
  logic        bram_en_o;
  logic [3:0]  bram_we_o;
  logic [31:0] bram_a_o, bram_di_o;
  logic [31:0] bram_do;

  int n_cmp;
  int n_bad;

  // BRAM model with a preload port
  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx;
  logic [31:0] pl_dat;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_dat;
    end else if (bram_en_o) begin
      for (int b = 0; b < 4; b++)
        if (bram_we_o[b]) mem[bram_a_o[9:2]][8*b +: 8] <= bram_di_o[8*b +: 8];
      bram_do <= mem[bram_a_o[9:2]];
    end
  end

  bram_access_arbiter dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .wbs_cyc_i   (wbs_cyc),
    .wbs_stb_i   (wbs_stb),
    .wbs_we_i    (wbs_we),
    .wbs_sel_i   (wbs_sel),
    .wbs_adr_i   (wbs_adr),
    .wbs_dat_i   (wbs_dat),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .eng_req_i   (eng_req),
    .eng_we_i    (eng_we),
    .eng_sel_i   (eng_sel),
    .eng_adr_i   (eng_adr),
    .eng_dat_i   (eng_dat),
    .eng_gnt_o   (eng_gnt_o),
    .eng_done_o  (eng_done_o),
    .eng_rdata_o (eng_rdata_o),
    .bram_en_o   (bram_en_o),
    .bram_we_o   (bram_we_o),
    .bram_a_o    (bram_a_o),
    .bram_di_o   (bram_di_o),
    .bram_do_i   (bram_do)
  );

  task automatic preload(input int idx, input logic [31:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_idx = idx[7:0]; pl_dat = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    preload(4, 32'hDEAD_BEEF);
    preload(5, 32'hAABB_CCDD);
    preload(6, 32'h0BAD_C0DE);
    preload(7, 32'h1122_3344);
    preload(8, 32'h5566_7788);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bram_en_o !== 1'b0) begin n_bad++; $display("FAIL rst.en got %0b want 0", bram_en_o); end
    n_cmp++; if (bram_we_o !== 4'h0) begin n_bad++; $display("FAIL rst.we got %h want 0", bram_we_o); end
    n_cmp++; if (bram_a_o !== 32'h0) begin n_bad++; $display("FAIL rst.a got %h want 0", bram_a_o); end
    n_cmp++; if (bram_di_o !== 32'h0) begin n_bad++; $display("FAIL rst.di got %h want 0", bram_di_o); end
    n_cmp++; if (wbs_ack_o !== 1'b0) begin n_bad++; $display("FAIL rst.ack got %0b want 0", wbs_ack_o); end
    n_cmp++; if (wbs_dat_o !== 32'h0) begin n_bad++; $display("FAIL rst.wdat got %h want 0", wbs_dat_o); end
    n_cmp++; if (eng_gnt_o !== 1'b0) begin n_bad++; $display("FAIL rst.gnt got %0b want 0", eng_gnt_o); end
    n_cmp++; if (eng_done_o !== 1'b0) begin n_bad++; $display("FAIL rst.done got %0b want 0", eng_done_o); end
    n_cmp++; if (eng_rdata_o !== 32'h0) begin n_bad++; $display("FAIL rst.rdata got %h want 0", eng_rdata_o); end
    $display("txn reset: outputs checked");
  endtask

  task automatic test_wb_read();
    logic exp_en;
    @(posedge clk); #1;
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 0; wbs_sel = 4'hF; wbs_adr = 32'h3800_0010; wbs_dat = 0;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      exp_en = (c >= 1 && c <= 10);
      n_cmp++; if (bram_en_o !== exp_en) begin n_bad++; $display("FAIL rd.en c%0d got %0b want %0b", c, bram_en_o, exp_en); end
      n_cmp++; if (bram_we_o !== 4'h0) begin n_bad++; $display("FAIL rd.we c%0d got %h want 0", c, bram_we_o); end
      n_cmp++; if (wbs_ack_o !== (c == 11)) begin n_bad++; $display("FAIL rd.ack c%0d got %0b want %0b", c, wbs_ack_o, c == 11); end
      if (exp_en) begin
        n_cmp++; if (bram_a_o !== 32'h3800_0010) begin n_bad++; $display("FAIL rd.adr c%0d got %h want 38000010", c, bram_a_o); end
      end
      if (c == 11) begin
        n_cmp++; if (wbs_dat_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd.data got %h want deadbeef", wbs_dat_o); end
        @(posedge clk); #1;
        wbs_cyc = 0; wbs_stb = 0;
      end
      if (c == 12) begin
        n_cmp++; if (wbs_dat_o !== 32'h0) begin n_bad++; $display("FAIL rd.dat_idle got %h want 0", wbs_dat_o); end
      end
    end
    $display("txn wb_read adr=38000010 data=%h", 32'hDEAD_BEEF);
  endtask

  task automatic test_wb_write();
    logic       exp_en;
    logic [3:0] exp_we;
    @(posedge clk); #1;
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 1; wbs_sel = 4'b0011; wbs_adr = 32'h3800_0014; wbs_dat = 32'h1234_5678;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      exp_en = (c >= 1 && c <= 10);
      exp_we = (c == 9 || c == 10) ? 4'b0011 : 4'b0000;
      n_cmp++; if (bram_en_o !== exp_en) begin n_bad++; $display("FAIL wr.en c%0d got %0b want %0b", c, bram_en_o, exp_en); end
      n_cmp++; if (bram_we_o !== exp_we) begin n_bad++; $display("FAIL wr.we c%0d got %h want %h", c, bram_we_o, exp_we); end
      n_cmp++; if (wbs_ack_o !== (c == 11)) begin n_bad++; $display("FAIL wr.ack c%0d got %0b want %0b", c, wbs_ack_o, c == 11); end
      if (exp_en) begin
        n_cmp++; if (bram_di_o !== 32'h1234_5678) begin n_bad++; $display("FAIL wr.di c%0d got %h want 12345678", c, bram_di_o); end
      end
      if (c == 11) begin
        @(posedge clk); #1;
        wbs_cyc = 0; wbs_stb = 0; wbs_we = 0;
      end
    end
    n_cmp++; if (mem[5] !== 32'hAABB_5678) begin n_bad++; $display("FAIL wr.mem got %h want aabb5678", mem[5]); end
    $display("txn wb_write adr=38000014 sel=0011 mem=%h", mem[5]);
  endtask

  task automatic test_abort();
    logic exp_en;
    @(posedge clk); #1;
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 1; wbs_sel = 4'hF; wbs_adr = 32'h3800_001C; wbs_dat = 32'hFFFF_FFFF;
    for (int c = 0; c <= 24; c++) begin
      @(negedge clk);
      exp_en = (c >= 1 && c <= 10) || (c >= 13 && c <= 22);
      n_cmp++; if (bram_en_o !== exp_en) begin n_bad++; $display("FAIL ab.en c%0d got %0b want %0b", c, bram_en_o, exp_en); end
      n_cmp++; if (bram_we_o !== 4'h0) begin n_bad++; $display("FAIL ab.we c%0d got %h want 0", c, bram_we_o); end
      n_cmp++; if (wbs_ack_o !== 1'b0) begin n_bad++; $display("FAIL ab.ack c%0d got %0b want 0", c, wbs_ack_o); end
      n_cmp++; if (eng_gnt_o !== (c == 12)) begin n_bad++; $display("FAIL ab.gnt c%0d got %0b want %0b", c, eng_gnt_o, c == 12); end
      n_cmp++; if (eng_done_o !== (c == 23)) begin n_bad++; $display("FAIL ab.done c%0d got %0b want %0b", c, eng_done_o, c == 23); end
      if (c >= 23) begin
        n_cmp++; if (eng_rdata_o !== 32'h1122_3344) begin n_bad++; $display("FAIL ab.rdata c%0d got %h want 11223344", c, eng_rdata_o); end
      end
      if (c == 4) begin
        @(posedge clk); #1;
        wbs_cyc = 0; wbs_stb = 0; wbs_we = 0;
      end
      if (c == 11) begin
        @(posedge clk); #1;
        eng_req = 1; eng_we = 0; eng_sel = 4'hF; eng_adr = 32'h3800_001C; eng_dat = 0;
      end
      if (c == 12) begin
        @(posedge clk); #1;
        eng_req = 0;
      end
    end
    n_cmp++; if (mem[7] !== 32'h1122_3344) begin n_bad++; $display("FAIL ab.mem got %h want 11223344", mem[7]); end
    $display("txn wb_abort adr=3800001c then eng_read data=%h", eng_rdata_o);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    eng_req = 1; eng_we = 1; eng_sel = 4'hF; eng_adr = 32'h3800_0020; eng_dat = 32'hCAFE_F00D;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      n_cmp++; if (eng_gnt_o !== (c == 0)) begin n_bad++; $display("FAIL rm.gnt c%0d got %0b want %0b", c, eng_gnt_o, c == 0); end
      n_cmp++; if (bram_we_o !== 4'h0) begin n_bad++; $display("FAIL rm.we c%0d got %h want 0", c, bram_we_o); end
      if (c >= 1) begin
        n_cmp++; if (bram_a_o !== 32'h3800_0020) begin n_bad++; $display("FAIL rm.adr c%0d got %h want 38000020", c, bram_a_o); end
      end
      if (c == 0) begin
        @(posedge clk); #1;
        eng_req = 0; eng_adr = 32'h0; eng_dat = 32'h0;
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bram_en_o !== 1'b0) begin n_bad++; $display("FAIL rm.en_rst got %0b want 0", bram_en_o); end
    n_cmp++; if (bram_we_o !== 4'h0) begin n_bad++; $display("FAIL rm.we_rst got %h want 0", bram_we_o); end
    n_cmp++; if (bram_a_o !== 32'h0) begin n_bad++; $display("FAIL rm.a_rst got %h want 0", bram_a_o); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      n_cmp++; if (eng_done_o !== 1'b0) begin n_bad++; $display("FAIL rm.done c%0d got %0b want 0", c, eng_done_o); end
      n_cmp++; if (bram_en_o !== 1'b0) begin n_bad++; $display("FAIL rm.en c%0d got %0b want 0", c, bram_en_o); end
    end
    n_cmp++; if (mem[8] !== 32'h5566_7788) begin n_bad++; $display("FAIL rm.mem got %h want 55667788", mem[8]); end
    $display("txn eng_write_reset adr=38000020 mem=%h", mem[8]);
  endtask

  task automatic test_tie();
    int   m;
    logic win_wb;
    logic exp_en;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 0; wbs_sel = 4'hF; wbs_adr = 32'h3800_0010; wbs_dat = 0;
    eng_req = 1; eng_we = 0; eng_sel = 4'hF; eng_adr = 32'h3800_0018; eng_dat = 0;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      m      = c % 12;
      win_wb = FIXED || (((c / 12) % 2) == 0);
      exp_en = (m != 0 && m != 11);
      n_cmp++; if (bram_en_o !== exp_en) begin n_bad++; $display("FAIL tie.en c%0d got %0b want %0b", c, bram_en_o, exp_en); end
      n_cmp++; if (wbs_ack_o !== (m == 11 && win_wb)) begin n_bad++; $display("FAIL tie.ack c%0d got %0b want %0b", c, wbs_ack_o, m == 11 && win_wb); end
      n_cmp++; if (eng_done_o !== (m == 11 && !win_wb)) begin n_bad++; $display("FAIL tie.done c%0d got %0b want %0b", c, eng_done_o, m == 11 && !win_wb); end
      n_cmp++; if (eng_gnt_o !== (m == 0 && !win_wb)) begin n_bad++; $display("FAIL tie.gnt c%0d got %0b want %0b", c, eng_gnt_o, m == 0 && !win_wb); end
      if (exp_en) begin
        n_cmp++; if (bram_a_o !== (win_wb ? 32'h3800_0010 : 32'h3800_0018)) begin n_bad++; $display("FAIL tie.adr c%0d got %h want %h", c, bram_a_o, win_wb ? 32'h3800_0010 : 32'h3800_0018); end
      end
      if (m == 11 && win_wb) begin
        n_cmp++; if (wbs_dat_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL tie.wdat c%0d got %h want deadbeef", c, wbs_dat_o); end
        $display("txn tie c=%0d winner=wb data=%h", c, wbs_dat_o);
      end
      if (m == 11 && !win_wb) begin
        n_cmp++; if (eng_rdata_o !== 32'h0BAD_C0DE) begin n_bad++; $display("FAIL tie.rdata c%0d got %h want 0badc0de", c, eng_rdata_o); end
        $display("txn tie c=%0d winner=eng data=%h", c, eng_rdata_o);
      end
    end
    @(posedge clk); #1;
    wbs_cyc = 0; wbs_stb = 0; eng_req = 0;
    @(negedge clk);
    n_cmp++; if (bram_en_o !== 1'b0) begin n_bad++; $display("FAIL tie.end_en got %0b want 0", bram_en_o); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0;
    wbs_cyc = 0; wbs_stb = 0; wbs_we = 0; wbs_sel = 0; wbs_adr = 0; wbs_dat = 0;
    eng_req = 0; eng_we = 0; eng_sel = 0; eng_adr = 0; eng_dat = 0;
    test_reset();
    test_wb_read();
    test_wb_write();
    test_abort();
    test_reset_mid();
    test_tie();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
